// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: answers fetch lookups with a one-cycle
// inst_ready pulse and refills a whole line from the memory controller on a miss.
module icache #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int IDX_LO   = OFFSET_BITS + 2;
    localparam int TAG_LO   = IDX_LO + INDEX_BITS;
    localparam int TAG_BITS = 32 - TAG_LO;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    inst_ready_r;
    logic [31:0]             inst_out_r;
    logic [31:0]             inst_pc_r;
    logic                    mem_req_r;
    logic [31:0]             mem_addr_r;
    logic [LINES-1:0]        valid_r;
    logic [TAG_BITS-1:0]     tag_r [LINES];
    logic [31:0]             data_r [LINES*WORDS];

    logic [TAG_BITS-1:0]     pc_tag_s;
    logic [INDEX_BITS-1:0]   pc_index_s;
    logic [OFFSET_BITS-1:0]  pc_offset_s;
    logic [TAG_BITS-1:0]     fill_tag_s;
    logic [INDEX_BITS-1:0]   fill_index_s;
    logic [OFFSET_BITS-1:0]  fill_off_s;
    logic [31:0]             line_base_s;
    logic [31:0]             hit_word_s;
    logic                    hit_s;
    logic                    lookup_hit_s;
    logic                    start_fill_s;
    logic                    fill_write_s;
    logic                    fill_last_s;

    assign pc_tag_s     = fetch_pc[31:TAG_LO];
    assign pc_index_s   = fetch_pc[TAG_LO-1:IDX_LO];
    assign pc_offset_s  = fetch_pc[IDX_LO-1:2];
    assign fill_tag_s   = mem_addr_r[31:TAG_LO];
    assign fill_index_s = mem_addr_r[TAG_LO-1:IDX_LO];
    assign fill_off_s   = mem_addr_r[IDX_LO-1:2];
    assign line_base_s  = {fetch_pc[31:IDX_LO], {IDX_LO{1'b0}}};
    assign hit_word_s   = data_r[{pc_index_s, pc_offset_s}];
    assign hit_s        = valid_r[pc_index_s] && (tag_r[pc_index_s] == pc_tag_s);

    assign inst_ready = inst_ready_r;
    assign inst_out   = inst_out_r;
    assign inst_pc    = inst_pc_r;
    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;

    // Next-state and per-cycle action strobes.
    // A flush during FILL needs no bookkeeping: the fill runs to completion and the
    // following IDLE lookup serves whatever fetch_pc is current, never the abandoned one.
    always_comb begin
        state_next_s = state_r;
        lookup_hit_s = 1'b0;
        start_fill_s = 1'b0;
        fill_write_s = 1'b0;
        fill_last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fetch_req && !clear) begin
                    if (hit_s) begin
                        lookup_hit_s = 1'b1;
                        state_next_s = ST_RESP;
                    end else begin
                        start_fill_s = 1'b1;
                        state_next_s = ST_FILL;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            ST_FILL: begin
                if (mem_ack) begin
                    fill_write_s = 1'b1;
                    if (fill_off_s == {OFFSET_BITS{1'b1}}) begin
                        fill_last_s  = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, response and fill-control registers; everything freezes while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            inst_ready_r <= 1'b0;
            inst_out_r   <= 32'h0000_0000;
            inst_pc_r    <= 32'h0000_0000;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            valid_r      <= '0;
        end else if (rdy) begin
            state_r      <= state_next_s;
            inst_ready_r <= lookup_hit_s;
            if (lookup_hit_s) begin
                inst_out_r <= hit_word_s;
                inst_pc_r  <= fetch_pc;
            end
            if (start_fill_s) begin
                mem_req_r           <= 1'b1;
                mem_addr_r          <= line_base_s;
                valid_r[pc_index_s] <= 1'b0;
            end
            if (fill_write_s) begin
                // Offset wraps inside the line, so mem_addr returns to the base after the last word.
                mem_addr_r <= {mem_addr_r[31:IDX_LO], fill_off_s + OFFSET_BITS'(1), 2'b00};
                if (fill_last_s) begin
                    valid_r[fill_index_s] <= 1'b1;
                    mem_req_r             <= 1'b0;
                end
            end
        end
    end

    // Tag and data arrays are not reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_write_s) begin
            data_r[{fill_index_s, fill_off_s}] <= mem_data;
            if (fill_last_s) begin
                tag_r[fill_index_s] <= fill_tag_s;
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: table-driven fetches, hand sequences for flush,
// stall and back-to-back corners, and random fetches against a line-residency model.
module tb_icache;
    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    icache dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory responder state
    int          ack_gap = 0;
    int          gap_cnt = 0;
    logic [31:0] acks_q[$];
    int          unstable = 0;
    logic        last_req = 1'b0;
    logic        last_ack = 1'b0;
    logic [31:0] last_addr = 32'h0;

    // reference model: which line base is resident at each index
    logic [31:0] model_base [16];
    bit          model_v [16];

    typedef struct {
        logic [31:0] pc;
        logic        exp_hit;
        logic [31:0] exp_word;
        int          gap;
    } vec_t;
    vec_t vecs [7];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return model_v[pc[7:4]] && (model_base[pc[7:4]] == {pc[31:4], 4'h0});
    endfunction

    task automatic model_put(input logic [31:0] pc);
        model_v[pc[7:4]]    = 1'b1;
        model_base[pc[7:4]] = {pc[31:4], 4'h0};
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_mem();
        if (!rdy) begin
            mem_ack  = 1'b1;
            mem_data = 32'hDEAD_BEEF;
        end else begin
            if (mem_req && last_req && !last_ack && mem_addr !== last_addr) unstable++;
            if (mem_req && gap_cnt == 0) begin
                mem_ack  = 1'b1;
                mem_data = mem_val(mem_addr);
                acks_q.push_back(mem_addr);
                gap_cnt  = ack_gap;
            end else begin
                mem_ack  = 1'b0;
                mem_data = 32'h0;
                if (gap_cnt > 0) gap_cnt--;
            end
            last_req  = mem_req;
            last_ack  = mem_ack;
            last_addr = mem_addr;
        end
    endtask

    // set memory inputs for the coming edge, then return #1 after that edge
    task automatic step();
        drive_mem();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic exp_hit,
                            input logic [31:0] exp_word, input int gap);
        int          cyc;
        bit          saw_req;
        bit          got;
        logic [31:0] base;
        base = {pc[31:4], 4'h0};
        ack_gap = gap; gap_cnt = 0; acks_q.delete(); unstable = 0;
        last_req = 1'b0; last_ack = 1'b0;
        fetch_pc = pc; fetch_req = 1'b1;
        cyc = 0; saw_req = 1'b0; got = 1'b0;
        while (!got && cyc < 200) begin
            step();
            cyc++;
            if (mem_req) saw_req = 1'b1;
            if (inst_ready) got = 1'b1;
        end
        check("pulse_seen", {31'b0, got}, 32'd1);
        check("inst_pc", inst_pc, pc);
        check("inst_out", inst_out, exp_word);
        check("mem_req_seen", {31'b0, saw_req}, {31'b0, !exp_hit});
        check("latency", 32'(cyc), exp_hit ? 32'd1 : 32'(6 + 3 * gap));
        if (!exp_hit) begin
            check("fill_count", 32'(acks_q.size()), 32'd4);
            for (int i = 0; i < acks_q.size(); i++)
                check("fill_addr", acks_q[i], base + 32'(4 * i));
            check("addr_stable", 32'(unstable), 32'd0);
            model_put(pc);
        end
        fetch_req = 1'b0;
        step();
        check("pulse_width", {31'b0, inst_ready}, 32'd0);
    endtask

    initial begin
        int cyc;
        bit got;
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; fetch_req = 1'b0; fetch_pc = 32'h0;
        mem_ack = 1'b0; mem_data = 32'h0;
        for (int i = 0; i < 16; i++) begin model_v[i] = 1'b0; model_base[i] = 32'h0; end
        step(); step();
        rst = 1'b0;
        check("rst_inst_ready", {31'b0, inst_ready}, 32'd0);
        check("rst_inst_out", inst_out, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);

        vecs[0] = '{32'h0000_0000, 1'b0, 32'h0000_0100, 0};
        vecs[1] = '{32'h0000_0008, 1'b1, 32'h0000_0102, 0};
        vecs[2] = '{32'h0000_0004, 1'b1, 32'h0000_0101, 0};
        vecs[3] = '{32'h0000_0100, 1'b0, 32'h0000_0140, 0};
        vecs[4] = '{32'h0000_0000, 1'b0, 32'h0000_0100, 0};
        vecs[5] = '{32'h0000_0050, 1'b0, 32'h0000_0114, 2};
        vecs[6] = '{32'h0000_005C, 1'b1, 32'h0000_0117, 0};
        for (int v = 0; v < 7; v++)
            do_fetch(vecs[v].pc, vecs[v].exp_hit, vecs[v].exp_word, vecs[v].gap);

        // back-to-back hits: one pulse every two cycles
        fetch_req = 1'b1; fetch_pc = 32'h50;
        step();
        check("b2b_ready0", {31'b0, inst_ready}, 32'd1);
        check("b2b_pc0", inst_pc, 32'h50);
        fetch_pc = 32'h54;
        step();
        check("b2b_gap", {31'b0, inst_ready}, 32'd0);
        step();
        check("b2b_ready1", {31'b0, inst_ready}, 32'd1);
        check("b2b_pc1", inst_pc, 32'h54);
        check("b2b_out1", inst_out, 32'h115);
        fetch_req = 1'b0;
        step();

        // flush in the second FILL cycle; fetch_pc moves to a cached line
        ack_gap = 0; gap_cnt = 0;
        fetch_pc = 32'h40; fetch_req = 1'b1;
        step();
        check("clr_fill_start", {31'b0, mem_req}, 32'd1);
        step();
        clear = 1'b1; fetch_pc = 32'h0;
        step();
        clear = 1'b0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 30) begin step(); cyc++; if (inst_ready) got = 1'b1; end
        check("clr_pulse_seen", {31'b0, got}, 32'd1);
        check("clr_pc", inst_pc, 32'h0);
        check("clr_out", inst_out, 32'h100);
        check("clr_latency", 32'(cyc), 32'd3);
        fetch_req = 1'b0;
        step();
        model_put(32'h40);
        do_fetch(32'h40, 1'b1, 32'h110, 0);

        // rdy stall mid-fill with mem_ack asserted throughout the stall
        ack_gap = 0; gap_cnt = 0;
        fetch_pc = 32'h80; fetch_req = 1'b1;
        step();
        step();
        check("stall_addr_pre", mem_addr, 32'h84);
        rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check("stall_addr", mem_addr, 32'h84);
            check("stall_req", {31'b0, mem_req}, 32'd1);
        end
        rdy = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 30) begin step(); cyc++; if (inst_ready) got = 1'b1; end
        check("stall_pulse_seen", {31'b0, got}, 32'd1);
        check("stall_latency", 32'(cyc), 32'd4);
        check("stall_pc", inst_pc, 32'h80);
        check("stall_out", inst_out, 32'h120);
        fetch_req = 1'b0;
        step();
        model_put(32'h80);
        do_fetch(32'h84, 1'b1, 32'h121, 0);
        do_fetch(32'h8C, 1'b1, 32'h123, 0);

        // random fetches against the residency model
        for (int r = 0; r < 40; r++) begin
            logic [31:0] pc;
            int          g;
            pc = 32'($urandom_range(0, 191)) << 2;
            g  = int'($urandom_range(0, 2));
            do_fetch(pc, model_hit(pc), mem_val(pc), g);
        end

        // reset invalidates every line
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model_v[i] = 1'b0;
        do_fetch(32'h0, 1'b0, 32'h100, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
